// File: rtl/prng_pkg.sv
// prng_pkg: shared state enum, word width, default FIFO depth and mask helper for the range sampler
package prng_pkg;
  localparam int WORD_W = 32;
  localparam int FIFO_DEPTH_DEF = 4;
  typedef enum logic [1:0] {UNCONF, MASK, RUN} state_e;
  function automatic logic [WORD_W-1:0] mask_of(input logic [WORD_W-1:0] n);
    logic [WORD_W-1:0] m;
    m = n - 32'd1;
    for (int i = 1; i < WORD_W; i <<= 1) m |= m >> i;
    return m;
  endfunction
endpackage

// File: rtl/prng_range_sampler_if.sv
// prng_range_sampler_if: PRNG input, bound load and sample output bus; rej_count only with PRNG_SAMPLER_REJCNT_EN
interface prng_range_sampler_if;
  import prng_pkg::*;
  logic [WORD_W-1:0] in_word;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] bound;
  logic              bound_load;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        level;
`ifdef PRNG_SAMPLER_REJCNT_EN
  logic [15:0]       rej_count;
`endif
  modport master(
    output in_word, in_valid, bound, bound_load, out_ready,
    input  in_ready, out_data, out_valid, level
`ifdef PRNG_SAMPLER_REJCNT_EN
    , input rej_count
`endif
  );
  modport slave(
    input  in_word, in_valid, bound, bound_load, out_ready,
    output in_ready, out_data, out_valid, level
`ifdef PRNG_SAMPLER_REJCNT_EN
    , output rej_count
`endif
  );
endinterface

// File: rtl/prng_sample_fifo.sv
// prng_sample_fifo: synchronous FIFO with push, pop, flush and occupancy; storage is not reset
module prng_sample_fifo import prng_pkg::*; #(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic [4:0]        level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [4:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign do_push = push && !flush && cnt_q < 5'(FIFO_DEPTH);
  assign do_pop = pop && !flush && cnt_q != 5'd0;
  always_comb begin
    wr_d = flush ? '0 : wr_q + AW'(do_push);
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush ? '0 : cnt_q + 5'(do_push) - 5'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_q] <= din;
  assign dout = cnt_q != 5'd0 ? mem[rd_q] : '0;
  assign level = cnt_q;
endmodule

// File: rtl/prng_range_sampler.sv
// prng_range_sampler: masks and rejection-samples PRNG words into [0, N) and buffers them; PRNG_SAMPLER_REJCNT_EN adds rej_count
module prng_range_sampler import prng_pkg::*; #(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic               clk,
  input logic               rst_n,
  prng_range_sampler_if.slave bus
);
  state_e state_q, state_d;
  logic [WORD_W-1:0] bound_q, bound_d, mask_q, mask_d, sample;
  logic hs, accept;
  always_comb begin
    state_d = bus.bound_load ? MASK : state_q == MASK ? RUN : state_q;
    bound_d = bus.bound_load ? bus.bound : bound_q;
    mask_d = state_q == MASK ? mask_of(bound_q) : mask_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= UNCONF;
      bound_q <= '0;
      mask_q <= '0;
    end else begin
      state_q <= state_d;
      bound_q <= bound_d;
      mask_q <= mask_d;
    end
  end
  assign bus.in_ready = state_q == RUN && bus.level < 5'(FIFO_DEPTH) && !bus.bound_load;
  assign hs = bus.in_valid && bus.in_ready;
  assign sample = bus.in_word & mask_q;
  assign accept = hs && (bound_q == '0 || sample < bound_q);
  assign bus.out_valid = bus.level != 5'd0;
  prng_sample_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(accept),
    .pop(bus.out_ready),
    .flush(bus.bound_load),
    .din(sample),
    .dout(bus.out_data),
    .level(bus.level)
  );
`ifdef PRNG_SAMPLER_REJCNT_EN
  logic [15:0] rej_q, rej_d;
  always_comb rej_d = bus.bound_load ? '0 : (hs && !accept && rej_q != 16'hFFFF) ? rej_q + 16'd1 : rej_q;
  always_ff @(posedge clk) rej_q <= !rst_n ? '0 : rej_d;
  assign bus.rej_count = rej_q;
`endif
endmodule

// File: tb/tb_prng_range_sampler.sv
// tb_prng_range_sampler: table vectors, directed corner sequences and a queue-based random reference model
module tb_prng_range_sampler;
  import prng_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  prng_range_sampler_if bus();
  prng_range_sampler #(.FIFO_DEPTH(4)) dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  typedef struct {
    logic [31:0] bnd;
    logic [31:0] word;
    logic        acc;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[10];
  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [31:0] mb, mm, s;
  int since, rej;
  logic exp_rdy, pop, hs;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [31:0] b);
    bus.bound = b;
    bus.bound_load = 1;
    step();
    bus.bound_load = 0;
    step();
  endtask
  function automatic logic [31:0] ref_mask(input logic [31:0] n);
    longint m = 0;
    if (n == 0) return 32'hFFFF_FFFF;
    while (m < longint'(n) - 1) m = m * 2 + 1;
    return 32'(m);
  endfunction
  function automatic logic [31:0] pick_bound();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'($urandom_range(2, 50));
      3: return $urandom;
      default: return 32'h8000_0000;
    endcase
  endfunction
  initial begin
    logic [31:0] s30[3];
    vt[0] = '{32'd10, 32'h13, 1'b1, 32'd3};
    vt[1] = '{32'd10, 32'h0F, 1'b0, 32'd0};
    vt[2] = '{32'd10, 32'h05, 1'b1, 32'd5};
    vt[3] = '{32'd0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    vt[4] = '{32'd1, 32'h12345678, 1'b1, 32'd0};
    vt[5] = '{32'd1, 32'hFFFFFFFF, 1'b1, 32'd0};
    vt[6] = '{32'd6, 32'h7, 1'b0, 32'd0};
    vt[7] = '{32'd6, 32'hFD, 1'b1, 32'd5};
    vt[8] = '{32'd256, 32'h1FF, 1'b1, 32'hFF};
    vt[9] = '{32'h80000001, 32'hFFFFFFFF, 1'b0, 32'd0};
    s30 = '{32'h13, 32'h0F, 32'h05};
    bus.in_word = 32'h55;
    bus.in_valid = 1;
    bus.bound = 0;
    bus.bound_load = 0;
    bus.out_ready = 0;
    step();
    step();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_out_data", bus.out_data, 0);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("unconf_in_ready", bus.in_ready, 0);
      chk("unconf_out_valid", bus.out_valid, 0);
    end
    bus.in_valid = 0;
    for (int i = 0; i < 10; i++) begin
      load(vt[i].bnd);
      bus.in_word = vt[i].word;
      bus.in_valid = 1;
      #1;
      chk("vec_in_ready", bus.in_ready, 1);
      step();
      bus.in_valid = 0;
      chk("vec_level", bus.level, 32'(vt[i].acc));
      chk("vec_out_valid", bus.out_valid, 32'(vt[i].acc));
      chk("vec_out_data", bus.out_data, vt[i].acc ? vt[i].exp : 32'd0);
      bus.out_ready = 1;
      step();
      bus.out_ready = 0;
    end
    load(10);
    bus.in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.in_word = s30[i];
      step();
    end
    bus.in_valid = 0;
    chk("b10_level", bus.level, 2);
    chk("b10_first", bus.out_data, 3);
`ifdef PRNG_SAMPLER_REJCNT_EN
    chk("b10_rej", bus.rej_count, 1);
`endif
    bus.out_ready = 1;
    step();
    chk("b10_second", bus.out_data, 5);
    step();
    chk("b10_empty", bus.out_valid, 0);
    bus.out_ready = 0;
    load(0);
    bus.in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus.in_word = 32'(100 + i);
      step();
    end
    chk("full_level", bus.level, 4);
    chk("full_in_ready", bus.in_ready, 0);
    bus.in_word = 200;
    step();
    chk("full_hold_level", bus.level, 4);
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    #1;
    chk("pop_in_ready", bus.in_ready, 1);
    chk("pop_level", bus.level, 3);
    chk("pop_head", bus.out_data, 101);
    step();
    chk("refill_level", bus.level, 4);
    chk("refill_in_ready", bus.in_ready, 0);
    bus.in_valid = 0;
    bus.out_ready = 1;
    step();
    chk("pre_flush_level", bus.level, 3);
    bus.bound = 6;
    bus.bound_load = 1;
    bus.in_valid = 1;
    bus.in_word = 0;
    #1;
    chk("load_in_ready", bus.in_ready, 0);
    step();
    bus.bound_load = 0;
    bus.out_ready = 0;
    chk("flush_level", bus.level, 0);
    chk("flush_out_valid", bus.out_valid, 0);
    chk("mask_in_ready", bus.in_ready, 0);
    step();
    chk("mask_level", bus.level, 0);
    q.delete();
    since = 1;
    mb = 6;
    mm = ref_mask(6);
    rej = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.bound_load = $urandom_range(0, 60) == 0;
      if (bus.bound_load) bus.bound = pick_bound();
      bus.in_valid = $urandom_range(0, 3) != 0;
      bus.in_word = $urandom;
      bus.out_ready = c[8] ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
      #1;
      exp_rdy = since >= 1 && q.size() < 4 && !bus.bound_load;
      chk("rnd_in_ready", bus.in_ready, 32'(exp_rdy));
      chk("rnd_level", bus.level, q.size());
      chk("rnd_out_valid", bus.out_valid, 32'(q.size() != 0));
      chk("rnd_out_data", bus.out_data, q.size() != 0 ? q[0] : 32'd0);
`ifdef PRNG_SAMPLER_REJCNT_EN
      chk("rnd_rej", bus.rej_count, 32'(rej));
`endif
      if (bus.bound_load) begin
        q.delete();
        since = 0;
        mb = bus.bound;
        mm = ref_mask(mb);
        rej = 0;
      end else begin
        pop = bus.out_ready && q.size() > 0;
        hs = bus.in_valid && exp_rdy;
        if (pop) void'(q.pop_front());
        if (hs) begin
          s = bus.in_word & mm;
          if (mb == 0 || s < mb) q.push_back(s);
          else if (rej < 65535) rej++;
        end
        if (since >= 0) since++;
      end
      step();
    end
    bus.in_valid = 0;
    bus.bound_load = 0;
    bus.out_ready = 0;
    load(0);
    bus.in_valid = 1;
    step();
    step();
    chk("mid_level", bus.level, 2);
    rst_n = 0;
    step();
    chk("mid_rst_level", bus.level, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    rst_n = 1;
    step();
    chk("post_rst_in_ready", bus.in_ready, 0);
    chk("post_rst_level", bus.level, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prng_range_sampler.md
PRNG_RANGE_SAMPLER -- requirements
Module: prng_range_sampler

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, number of buffered accepted samples (power of two, 2..16).
REQ-002 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port: in_word  input  32  raw word from the upstream PRNG.
REQ-005 SHALL have port: in_valid  input  1  in_word valid.
REQ-006 SHALL have port: in_ready  output  1  sampler consumes in_word; upstream advances its state on in_valid & in_ready.
REQ-007 SHALL have port: bound  input  32  exclusive upper limit N; 0 means the full 32-bit range.
REQ-008 SHALL have port: bound_load  input  1  single-cycle strobe capturing bound.
REQ-009 SHALL have port: out_data  output  32  oldest buffered sample, in [0, N).
REQ-010 SHALL have port: out_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port: out_ready  input  1  consumer pops on out_valid & out_ready.
REQ-012 SHALL have port: level  output  5  current FIFO occupancy.

Function
REQ-013 SHALL implement three states: UNCONF (after reset), MASK (one cycle after bound_load) and RUN; transitions: UNCONF/MASK/RUN -> MASK on bound_load, MASK -> RUN unconditionally.
REQ-014 SHALL, in MASK, register mask = bits at and below the MSB of (N-1) set; N=0 gives 0xFFFFFFFF, N=1 gives 0.
REQ-015 SHALL drive in_ready = (state==RUN) & (level<FIFO_DEPTH) & !bound_load, from registered state only, with no bypass from a same-cycle pop.
REQ-016 SHALL, on a handshake, form sample = in_word & mask and accept it iff N==0 or sample < N; an accepted sample is written to the FIFO on that edge.
REQ-017 SHALL discard rejected samples; in_ready stays high so the next word is consumed on the following cycle.
REQ-018 SHALL assert out_valid the cycle after the first accept, giving 1-cycle latency from handshake to out_valid.
REQ-019 SHALL, on a simultaneous push and pop, keep level unchanged and preserve order.
REQ-020 SHALL ignore a pop while empty; out_data is 0 whenever out_valid is low.
REQ-021 SHALL, on bound_load, flush the FIFO (level 0, out_valid 0 next cycle) and ignore any pop or handshake in that cycle.
REQ-022 SHALL wrap read and write pointers modulo FIFO_DEPTH.

Reset
REQ-023 SHALL, on rst_n low at a clock edge, set state UNCONF, mask 0, level 0, pointers 0, in_ready 0, out_valid 0 and out_data 0, aborting any in-flight operation.
REQ-024 SHALL NOT reset FIFO storage contents.

Configuration
REQ-025 SHALL, with PRNG_SAMPLER_REJCNT_EN defined, add output rej_count (16 bits) counting rejected handshakes, saturating at 0xFFFF and cleared by reset and by bound_load.
REQ-026 SHALL, without PRNG_SAMPLER_REJCNT_EN, have no rej_count port and no counter logic.

Structure
REQ-027 SHALL place the state enum, the 32-bit word width constant and the FIFO_DEPTH default in shared package prng_pkg.
REQ-028 SHALL implement the buffer as sub-module prng_sample_fifo (synchronous FIFO with push, pop, flush and level).

Verification
REQ-029 SHALL test that after reset with in_valid=1, in_ready stays 0 and out_valid stays 0 for 10 cycles.
REQ-030 SHALL test that bound=10 with in_word sequence 0x13, 0x0F, 0x05 gives mask 0xF, samples 3 accepted, 15 rejected and 5 accepted, so out_data is 3 then 5; with REJCNT_EN, rej_count=1.
REQ-031 SHALL test that bound=0 with in_word 0xDEADBEEF outputs 0xDEADBEEF with no rejection; bound=1 outputs 0 for every word.
REQ-032 SHALL test that FIFO_DEPTH=4 with out_ready=0 deasserts in_ready after 4 accepts (level=4), and that one pop with in_valid held leads to in_ready=1 and a push on the next cycle.
REQ-033 SHALL test that bound_load (bound=6) with level=3 gives level=0 and out_valid=0 the next cycle, no handshake for 2 cycles, then samples all below 6.
REQ-034 SHALL test that rst_n low mid-stream with level=2 gives level=0, state UNCONF and in_ready=0 on the next cycle.
